product_accumulator: RTL and testbench



---
 rtl/product_accumulator_if.sv | 31 +++
 rtl/product_accumulator.sv | 93 +++++++++
 tb/tb_product_accumulator.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/product_accumulator_if.sv
// Product-in / result-out bundle for the product accumulator.
//   prod_valid/prod_data/prod_last/prod_ready : product beat handshake
//   acc_clear                                  : discard the running batch
//   res_valid/res_ready/res_data/res_count/res_ovf : held batch result
// master = product source and result consumer; slave = the accumulator.
interface product_accumulator_if #(
    parameter int unsigned PROD_W = 8,
    parameter int unsigned ACC_W  = 16,
    parameter int unsigned CNT_W  = 4
);
    logic              prod_valid;
    logic [PROD_W-1:0] prod_data;
    logic              prod_last;
    logic              prod_ready;
    logic              acc_clear;
    logic              res_valid;
    logic              res_ready;
    logic [ACC_W-1:0]  res_data;
    logic [CNT_W-1:0]  res_count;
    logic              res_ovf;

    modport master (
        output prod_valid, prod_data, prod_last, acc_clear, res_ready,
        input  prod_ready, res_valid, res_data, res_count, res_ovf
    );

    modport slave (
        input  prod_valid, prod_data, prod_last, acc_clear, res_ready,
        output prod_ready, res_valid, res_data, res_count, res_ovf
    );
endinterface

// File: rtl/product_accumulator.sv
// Saturating multiply-accumulate back end: sums a batch of unsigned products
// and holds the total, beat count and overflow flag until the consumer takes it.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : product_accumulator_if slave (product handshake, clear, result port)
module product_accumulator #(
    parameter int unsigned PROD_W = 8,
    parameter int unsigned ACC_W  = 16,
    parameter int unsigned CNT_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    product_accumulator_if.slave  bus
);
    localparam int unsigned SUM_W = ACC_W + 1;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    // Clear-adjusted operands: a clear coincident with a beat makes the beat the first term
    logic [ACC_W-1:0] acc_base;
    logic [CNT_W-1:0] cnt_base;
    logic             ovf_base;
    logic [SUM_W-1:0] sum;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        acc_base = bus.acc_clear ? '0 : acc_q;
        cnt_base = bus.acc_clear ? '0 : cnt_q;
        ovf_base = bus.acc_clear ? 1'b0 : ovf_q;
        sum      = {1'b0, acc_base} + SUM_W'(bus.prod_data);

        case (state_q)
            ACCUM: begin
                acc_d = acc_base;
                cnt_d = cnt_base;
                ovf_d = ovf_base;
                if (bus.prod_valid) begin
                    // Carry out of the widened add means the sum no longer fits
                    acc_d = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
                    ovf_d = ovf_base | sum[ACC_W];
                    cnt_d = (cnt_base == {CNT_W{1'b1}}) ? cnt_base : cnt_base + CNT_W'(1);
                    if (bus.prod_last) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    // Outputs are state decodes or datapath registers only
    assign bus.prod_ready = (state_q == ACCUM);
    assign bus.res_valid  = (state_q == DONE);
    assign bus.res_data   = acc_q;
    assign bus.res_count  = cnt_q;
    assign bus.res_ovf    = ovf_q;
endmodule

// File: tb/tb_product_accumulator.sv
// Directed and randomized bench for product_accumulator (ACC_W = 10 so
// saturation is reachable with a few 0xFF beats).
module tb_product_accumulator;
    localparam int unsigned PROD_W = 8;
    localparam int unsigned ACC_W  = 10;
    localparam int unsigned CNT_W  = 4;
    localparam int MAX_ACC = (1 << ACC_W) - 1;
    localparam int MAX_CNT = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: batch sum, count, overflow and whether a result is held
    int m_sum  = 0;
    int m_cnt  = 0;
    bit m_ovf  = 1'b0;
    bit m_done = 1'b0;

    product_accumulator_if #(.PROD_W(PROD_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

    product_accumulator #(.PROD_W(PROD_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " res_valid"},  32'(bus.res_valid),  32'(m_done));
        chk({tag, " prod_ready"}, 32'(bus.prod_ready), 32'(!m_done));
        chk({tag, " res_data"},   32'(bus.res_data),   32'(m_sum));
        chk({tag, " res_count"},  32'(bus.res_count),  32'(m_cnt));
        chk({tag, " res_ovf"},    32'(bus.res_ovf),    32'(m_ovf));
    endtask

    task automatic model_reset();
        m_sum  = 0;
        m_cnt  = 0;
        m_ovf  = 1'b0;
        m_done = 1'b0;
    endtask

    // Apply one cycle of inputs, check the model before the edge, advance the model at the edge
    task automatic step(input logic v, input logic [7:0] d, input logic l,
                        input logic c, input logic r, input string tag);
        int raw;
        bus.prod_valid = v;
        bus.prod_data  = d;
        bus.prod_last  = l;
        bus.acc_clear  = c;
        bus.res_ready  = r;
        #1;
        chk_model(tag);
        @(posedge clk);
        if (!m_done) begin
            if (c) begin
                m_sum = 0;
                m_cnt = 0;
                m_ovf = 1'b0;
            end
            if (v) begin
                raw = m_sum + int'(d);
                if (raw > MAX_ACC) begin
                    m_sum = MAX_ACC;
                    m_ovf = 1'b1;
                end else begin
                    m_sum = raw;
                end
                if (m_cnt < MAX_CNT) m_cnt++;
                if (l) m_done = 1'b1;
            end
        end else if (r) begin
            model_reset();
        end
        #1;
    endtask

    task automatic idle(input logic r, input string tag);
        step(1'b0, 8'h00, 1'b0, 1'b0, r, tag);
    endtask

    initial begin
        bit v, l, c, r;
        logic [7:0] d;

        bus.prod_valid = 1'b0;
        bus.prod_data  = '0;
        bus.prod_last  = 1'b0;
        bus.acc_clear  = 1'b0;
        bus.res_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1;

        // Reset state
        chk("rst res_valid",  32'(bus.res_valid),  32'd0);
        chk("rst prod_ready", 32'(bus.prod_ready), 32'd1);
        chk("rst res_data",   32'(bus.res_data),   32'd0);
        chk("rst res_count",  32'(bus.res_count),  32'd0);
        chk("rst res_ovf",    32'(bus.res_ovf),    32'd0);

        // Basic batch
        step(1, 8'h10, 0, 0, 1, "basic0");
        step(1, 8'h20, 0, 0, 1, "basic1");
        step(1, 8'h30, 1, 0, 1, "basic2");
        chk("basic res_valid", 32'(bus.res_valid), 32'd1);
        chk("basic res_data",  32'(bus.res_data),  32'h60);
        chk("basic res_count", 32'(bus.res_count), 32'd3);
        chk("basic res_ovf",   32'(bus.res_ovf),   32'd0);
        idle(1, "basic_done");
        chk("basic one-cycle res_valid", 32'(bus.res_valid),  32'd0);
        chk("basic prod_ready back",     32'(bus.prod_ready), 32'd1);

        // Saturation, then a fresh batch shows ovf cleared
        for (int i = 0; i < 5; i++) step(1, 8'hFF, logic'(i == 4), 0, 0, "sat");
        chk("sat res_data",  32'(bus.res_data),  32'h3FF);
        chk("sat res_ovf",   32'(bus.res_ovf),   32'd1);
        chk("sat res_count", 32'(bus.res_count), 32'd5);
        idle(1, "sat_done");
        step(1, 8'h01, 1, 0, 0, "sat_next");
        chk("sat next res_data", 32'(bus.res_data), 32'h001);
        chk("sat next res_ovf",  32'(bus.res_ovf),  32'd0);
        idle(1, "sat_next_done");

        // Backpressure: result held, offered beats not absorbed
        step(1, 8'h05, 0, 0, 0, "bp0");
        step(1, 8'h07, 1, 0, 0, "bp1");
        for (int i = 0; i < 5; i++) begin
            step(1, 8'h55, 0, 0, 0, "bp_hold");
            chk("bp held data", 32'(bus.res_data),   32'h00C);
            chk("bp stalled",   32'(bus.prod_ready), 32'd0);
        end
        idle(1, "bp_accept");
        chk("bp after accept valid", 32'(bus.res_valid), 32'd0);
        chk("bp after accept data",  32'(bus.res_data),  32'd0);

        // Clear coincident with a last beat; clear ignored while holding
        step(1, 8'h40, 0, 0, 0, "clr0");
        step(1, 8'h40, 0, 0, 0, "clr1");
        step(1, 8'h03, 1, 1, 0, "clr2");
        chk("clr res_data",  32'(bus.res_data),  32'h003);
        chk("clr res_count", 32'(bus.res_count), 32'd1);
        step(0, 8'h00, 0, 1, 0, "clr_in_done");
        chk("clr in done data",  32'(bus.res_data),  32'h003);
        chk("clr in done valid", 32'(bus.res_valid), 32'd1);
        idle(1, "clr_done");

        // Count saturation
        for (int i = 0; i < 17; i++) step(1, 8'h01, logic'(i == 16), 0, 0, "cnt");
        chk("cnt res_count", 32'(bus.res_count), 32'd15);
        chk("cnt res_data",  32'(bus.res_data),  32'h011);
        idle(1, "cnt_done");

        // Asynchronous reset between edges
        step(1, 8'h22, 0, 0, 0, "ar0");
        step(1, 8'h33, 0, 0, 0, "ar1");
        bus.prod_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("async rst res_data",  32'(bus.res_data),   32'd0);
        chk("async rst res_count", 32'(bus.res_count),  32'd0);
        chk("async rst ready",     32'(bus.prod_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        step(1, 8'h09, 1, 0, 0, "ar_after");
        chk("async after data",  32'(bus.res_data),  32'h009);
        chk("async after count", 32'(bus.res_count), 32'd1);
        idle(1, "ar_done");

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 9) < 7);
            l = ($urandom_range(0, 9) < 2);
            c = ($urandom_range(0, 9) == 0);
            r = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 3))
                0:       d = 8'hFF;
                1:       d = 8'h00;
                default: d = 8'($urandom_range(0, 255));
            endcase
            step(v, d, l, c, r, "rand");
        end
        idle(1, "final");
        idle(1, "final2");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
